alu64: RTL and testbench
========================

Name: alu64

Overview:
64-bit combinational ALU for the LEGv8 single-cycle datapath. It computes the result and the zero flag from two 64-bit operands and a 4-bit control code. It also holds a clocked NZCV condition-flag register, loaded on request, for flag-setting instructions such as ADDS/SUBS. The result path has no latency. Only the flag register is clocked.

Parameters:
N, 64, operand/result width (all widths below refer to N)

Ports:
clk  input  1  clock; flag register samples on the rising edge
reset  input  1  asynchronous, active-low reset; clears the flag register
a  input  N  operand A
b  input  N  operand B
ALUcontrol  input  4  operation select
set_flags  input  1  when 1, load NZCV from the current operation at the next rising clk edge
y  output  N  result (combinational)
zero  output  1  1 when y == 0 (combinational)
flags  output  4  registered {N,Z,C,V}

Behaviour:
- Operation encoding for ALUcontrol, result y:
  - 4'b0000 AND: y = a & b
  - 4'b0001 OR: y = a | b
  - 4'b0010 ADD: y = a + b, modulo 2^N
  - 4'b0110 SUB: y = a - b, modulo 2^N
  - 4'b0111 PASS_B: y = b (used by CBZ)
  - 4'b1100 NOR: y = ~(a | b)
  - any other code: y = 0, so zero = 1
- y and zero are purely combinational. They settle within the same delta/evaluation as any change on a, b or ALUcontrol.
- zero = (y == 0) for every code, including default codes.
- Next-flag values, computed combinationally:
  - Nn = y[N-1]
  - Zn = zero
  - ADD: C = carry-out of bit N-1; V = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1])
  - SUB: computed as a + ~b + 1. C = carry-out, so 1 means no borrow (a >= b unsigned). V = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1])
  - All other codes: C = 0, V = 0
- Flag register:
  - reset low (asynchronous) sets flags = 4'b0000 immediately, independent of clk.
  - On rising clk with reset high and set_flags = 1: flags <= {Nn, Zn, C, V}.
  - On rising clk with set_flags = 0: flags hold their value.
  - If reset is asserted in the same cycle as set_flags, reset wins.
  - On reset release, flags stay 0 until the first qualifying edge.
- Operands are unsigned bit vectors. No saturation and no exceptions: overflow wraps.

Test Plan:
- a=2, b=3, ALUcontrol=0000 -> y=2, zero=0; a=2, b=3, ALUcontrol=0001 -> y=3, zero=0.
- a=3, b=3, ALUcontrol=0010 -> y=6, zero=0; a=3, b=3, ALUcontrol=0110 -> y=0, zero=1.
- a=0, b=0, ALUcontrol=0111 -> y=0, zero=1; a=5, b=0x1234, ALUcontrol=0111 -> y=0x1234, zero=0; ALUcontrol=1100, a=b=0 -> y=all ones, zero=0; ALUcontrol=1111 -> y=0, zero=1.
- set_flags=1, ADD with a=0x7FFF_FFFF_FFFF_FFFF, b=1, one clk edge -> flags=1001 (N=1, V=1); ADD with a=all ones, b=1 -> y=0, flags=0110 (Z=1, C=1).
- SUB a=3, b=5 with set_flags=1 -> y=0xFFFF_FFFF_FFFF_FFFE, flags=1000. Then set_flags=0 with new operands for 3 edges -> flags unchanged.
- Load flags to nonzero, then pull reset low between clock edges -> flags=0000 immediately. Hold reset low with set_flags=1 across an edge -> flags stay 0000. y and zero keep tracking their inputs throughout.

Source files
------------

// File: rtl/alu64.sv
`default_nettype none
// ============================================================================
// Module   : alu64
// Purpose  : LEGv8 datapath ALU. The result and zero outputs are combinational.
//            NZCV is held in a register and loaded when set_flags is high.
// Revision : 1.0  initial release
// ============================================================================
module alu64 #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUcontrol,
    input  logic         set_flags,
    output logic [N-1:0] y,
    output logic         zero,
    output logic [3:0]   flags
);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_PASS = 4'b0111;
    localparam logic [3:0] c_OP_NOR  = 4'b1100;

    logic         w_is_sub;
    logic [N-1:0] w_b_addend;
    logic [N:0]   w_sum;
    logic         w_carry;
    logic         w_ovf;
    logic [3:0]   w_next_flags;
    logic [3:0]   r_flags;

    // One shared adder: subtraction is a + ~b + 1, so carry-out = "no borrow".
    assign w_is_sub   = (ALUcontrol == c_OP_SUB);
    assign w_b_addend = w_is_sub ? ~b : b;
    assign w_sum      = {1'b0, a} + {1'b0, w_b_addend} + {{N{1'b0}}, w_is_sub};

    always_comb begin
        y = '0;
        case (ALUcontrol)
            c_OP_AND:  y = a & b;
            c_OP_OR:   y = a | b;
            c_OP_ADD:  y = w_sum[N-1:0];
            c_OP_SUB:  y = w_sum[N-1:0];
            c_OP_PASS: y = b;
            c_OP_NOR:  y = ~(a | b);
            default:   y = '0;
        endcase
    end

    assign zero = (y == '0);

    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (ALUcontrol == c_OP_ADD) begin
            w_carry = w_sum[N];
            w_ovf   = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
        end else if (w_is_sub) begin
            w_carry = w_sum[N];
            w_ovf   = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
        end
    end

    assign w_next_flags = {y[N-1], zero, w_carry, w_ovf};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (set_flags) begin
            r_flags <= w_next_flags;
        end
    end

    assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu64.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu64
// Purpose  : Randomized scoreboard bench for alu64 against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu64;

    logic        clk;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ALUcontrol;
    logic        set_flags;
    logic [63:0] y;
    logic        zero;
    logic [3:0]  flags;

    alu64 #(.N(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .ALUcontrol (ALUcontrol),
        .set_flags  (set_flags),
        .y          (y),
        .zero       (zero),
        .flags      (flags)
    );

    typedef struct packed {
        logic [63:0] y;
        logic        z;
        logic [3:0]  nf;
    } res_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] y;
        logic        z;
        logic [3:0]  flags;
    } txn_t;

    txn_t       sb_q[$];
    logic [3:0] exp_flags;
    int         vectors;
    int         miscompares;
    bit         stim_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: flags derived from wide unsigned / signed arithmetic.
    function automatic res_t model(input logic [63:0] fa, input logic [63:0] fb,
                                   input logic [3:0] op);
        res_t              r;
        logic [64:0]       u;
        logic signed [64:0] s;
        logic              c;
        logic              v;
        c = 1'b0;
        v = 1'b0;
        r.y = 64'd0;
        case (op)
            4'b0000: r.y = fa & fb;
            4'b0001: r.y = fa | fb;
            4'b0010: begin
                u   = {1'b0, fa} + {1'b0, fb};
                r.y = u[63:0];
                c   = u[64];
                s   = $signed({fa[63], fa}) + $signed({fb[63], fb});
                v   = s[64] ^ s[63];
            end
            4'b0110: begin
                r.y = fa - fb;
                c   = (fa >= fb);
                s   = $signed({fa[63], fa}) - $signed({fb[63], fb});
                v   = s[64] ^ s[63];
            end
            4'b0111: r.y = fb;
            4'b1100: r.y = ~(fa | fb);
            default: r.y = 64'd0;
        endcase
        r.z  = (r.y == 64'd0);
        r.nf = {r.y[63], r.z, c, v};
        return r;
    endfunction

    // Drive one vector between edges; the pushed flags are what the register
    // should show before the next rising edge.
    task automatic apply(input logic [63:0] ta, input logic [63:0] tb,
                         input logic [3:0] op, input logic sf, input logic rn);
        res_t r;
        txn_t t;
        @(posedge clk);
        #1;
        a          = ta;
        b          = tb;
        ALUcontrol = op;
        set_flags  = sf;
        reset      = rn;
        r = model(ta, tb, op);
        if (!rn) exp_flags = 4'b0000;
        t.op    = op;
        t.y     = r.y;
        t.z     = r.z;
        t.flags = exp_flags;
        sb_q.push_back(t);
        if (rn && sf) exp_flags = r.nf;
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            txn_t t;
            t = sb_q.pop_front();
            vectors++;
            if (y !== t.y) begin
                miscompares++;
                $display("FAIL y op=%b: got %h expected %h", t.op, y, t.y);
            end
            if (zero !== t.z) begin
                miscompares++;
                $display("FAIL zero op=%b: got %b expected %b", t.op, zero, t.z);
            end
            if (flags !== t.flags) begin
                miscompares++;
                $display("FAIL flags op=%b: got %b expected %b", t.op, flags, t.flags);
            end
        end
    end

    initial begin
        logic [3:0] ops [8];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1111; ops[7] = 4'b0011;
        vectors     = 0;
        miscompares = 0;
        stim_done   = 1'b0;
        exp_flags   = 4'b0000;
        reset       = 1'b0;
        a           = 64'd0;
        b           = 64'd0;
        ALUcontrol  = 4'b0000;
        set_flags   = 1'b0;

        apply(64'd2, 64'd3, 4'b0000, 1'b1, 1'b0);
        apply(64'd2, 64'd3, 4'b0001, 1'b0, 1'b1);
        apply(64'd3, 64'd3, 4'b0010, 1'b0, 1'b1);
        apply(64'd3, 64'd3, 4'b0110, 1'b0, 1'b1);
        apply(64'd0, 64'd0, 4'b0111, 1'b0, 1'b1);
        apply(64'd5, 64'h1234, 4'b0111, 1'b0, 1'b1);
        apply(64'd0, 64'd0, 4'b1100, 1'b0, 1'b1);
        apply(64'd9, 64'd7, 4'b1111, 1'b0, 1'b1);
        apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1, 1'b1);
        apply({64{1'b1}}, 64'd1, 4'b0010, 1'b1, 1'b1);
        apply(64'd3, 64'd5, 4'b0110, 1'b1, 1'b1);
        apply(64'd11, 64'd11, 4'b0110, 1'b0, 1'b1);
        apply(64'h8000_0000_0000_0000, 64'd1, 4'b0010, 1'b0, 1'b1);
        apply(64'd0, 64'd0, 4'b0000, 1'b0, 1'b1);
        // Reset pulled low between edges, then held low across a set_flags edge.
        apply(64'd4, 64'd4, 4'b0010, 1'b0, 1'b0);
        apply(64'h8000_0000_0000_0000, 64'd1, 4'b0110, 1'b1, 1'b0);
        apply(64'd1, 64'd2, 4'b0001, 1'b0, 1'b1);
        apply(64'd1, 64'd2, 4'b0110, 1'b1, 1'b1);

        for (int i = 0; i < 300; i++) begin
            apply(pick_operand(), pick_operand(), ops[$urandom_range(0, 7)],
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0));
        end

        repeat (3) @(posedge clk);
        stim_done = 1'b1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        if (!stim_done) begin
            $display("FAIL timeout: got no completion expected finish before 1ms");
            $fatal(1, "timeout");
        end
    end

endmodule
`default_nettype wire
